// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, addresses the instruction cache with it, and
// queues every hit word together with its PC into a small ordered FIFO that
// decode drains via valid/ready. A miss simply holds the PC until the cache
// reports a hit; a redirect flushes the queue and reloads the PC.
module inst_fetch #(
    parameter int                        WORD_SIZE = 32,
    parameter int                        DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0]      RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD_SIZE-1:0] icache_ptr,
    input  logic [WORD_SIZE-1:0] icache_out,
    input  logic                 icache_hit,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [WORD_SIZE-1:0] inst_out,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic [WORD_SIZE-1:0] stall_count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    C_DEPTH = (PW + 1)'(DEPTH);

    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_mem_inst [DEPTH];
    logic [WORD_SIZE-1:0] r_mem_pc   [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW:0]          r_count;
    logic [WORD_SIZE-1:0] r_stall;

    logic w_pop;
    logic w_fetch_en;
    logic w_push;
    logic w_pop_eff;
    logic w_stall;

    // Handshake and fetch-enable decode; a full queue may still accept a
    // word when decode frees a slot in the same cycle. Redirect suppresses
    // both the push and the pop so the flush wins cleanly.
    always_comb begin
        w_pop      = inst_valid & inst_ready;
        w_fetch_en = (r_count < C_DEPTH) | w_pop;
        w_push     = w_fetch_en & icache_hit & ~redirect_valid;
        w_pop_eff  = w_pop & ~redirect_valid;
        w_stall    = w_fetch_en & ~icache_hit & ~redirect_valid;
    end

    assign icache_ptr  = r_pc;
    assign inst_valid  = (r_count != '0);
    assign inst_out    = r_mem_inst[r_rd_ptr];
    assign inst_pc     = r_mem_pc[r_rd_ptr];
    assign stall_count = r_stall;

    // Program counter: advances only on an accepted hit, reloads on redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_mem_inst[r_wr_ptr] <= icache_out;
            r_mem_pc[r_wr_ptr]   <= r_pc;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop_eff})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of cycles spent waiting on a cache miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: a tiny combinational cache model returns
// a word derived from the address, and each step checks the state seen just
// after the clock edge against hand-computed values.
module tb_inst_fetch;

    localparam logic [31:0] SALT = 32'h5A5A_0000;

    logic        clk;
    logic        rst;
    logic [31:0] icache_ptr;
    logic [31:0] icache_out;
    logic        icache_hit;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] stall_count;

    int testsRun;
    int testsFailed;

    inst_fetch #(
        .WORD_SIZE (32),
        .DEPTH     (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_ptr     (icache_ptr),
        .icache_out     (icache_out),
        .icache_hit     (icache_hit),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .stall_count    (stall_count)
    );

    // Cache model: the word at an address is the address xor a fixed salt.
    assign icache_out = icache_ptr ^ SALT;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, then settle just after it.
    task automatic applyStimulus(input logic r, input logic hit, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        rst            = r;
        icache_hit     = hit;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        rst            = 1'b1;
        icache_hit     = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_out",   inst_out,    32'h0);
        checkOutput("rst_pc",    inst_pc,     32'h0);
        checkOutput("rst_ptr",   icache_ptr,  32'h0);
        checkOutput("rst_stall", stall_count, 32'h0);

        // Continuous hits with decode ready: one instruction per cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 1, 0, 32'h0);
            checkOutput("run_ptr",   icache_ptr, 32'(i + 1));
            checkOutput("run_valid", {31'b0, inst_valid}, 32'h1);
            checkOutput("run_pc",    inst_pc,  32'(i));
            checkOutput("run_out",   inst_out, 32'(i) ^ SALT);
        end
        checkOutput("run_stall", stall_count, 32'h0);

        // Back-pressure after a fresh reset: exactly four pushes, PC stops at 4
        applyStimulus(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h0);
            checkOutput("full_pc",  inst_pc, 32'h0);
            checkOutput("full_ptr", icache_ptr, (i < 4) ? 32'(i + 1) : 32'h4);
        end
        checkOutput("full_stall", stall_count, 32'h0);

        // Release decode: pop at full with a same-cycle push
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 1, 0, 32'h0);
            checkOutput("drain_pc",  inst_pc,    32'(i));
            checkOutput("drain_out", inst_out,   32'(i) ^ SALT);
            checkOutput("drain_ptr", icache_ptr, 32'(i + 4));
        end

        // Redirect to 33 while full, with hit and ready high
        applyStimulus(0, 1, 1, 1, 32'd33);
        checkOutput("redir_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("redir_ptr",   icache_ptr, 32'd33);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("redir_first_pc",  inst_pc,  32'd33);
        checkOutput("redir_first_out", inst_out, 32'd33 ^ SALT);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("redir_next_pc", inst_pc, 32'd34);

        // Three-cycle miss at PC 21
        applyStimulus(0, 1, 1, 1, 32'd21);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 1, 0, 32'h0);
            checkOutput("miss_ptr",   icache_ptr, 32'd21);
            checkOutput("miss_valid", {31'b0, inst_valid}, 32'h0);
            checkOutput("miss_stall", stall_count, 32'(i));
        end
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("miss_hit_pc",  inst_pc,    32'd21);
        checkOutput("miss_hit_ptr", icache_ptr, 32'd22);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("miss_once_pc", inst_pc,     32'd22);
        checkOutput("miss_stall_f", stall_count, 32'd3);

        // PC wrap from all-ones to zero
        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFF);
        checkOutput("wrap_ptr0", icache_ptr, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("wrap_pc0",  inst_pc,    32'hFFFF_FFFF);
        checkOutput("wrap_ptr1", icache_ptr, 32'h0);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkOutput("wrap_pc1",  inst_pc,    32'h0);
        checkOutput("wrap_ptr2", icache_ptr, 32'h1);

        // Reset during a miss with a non-empty queue
        applyStimulus(0, 1, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("pre_rst_stall", stall_count, 32'd4);
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("mid_rst_ptr",   icache_ptr,  32'h0);
        checkOutput("mid_rst_stall", stall_count, 32'h0);
        checkOutput("mid_rst_pc",    inst_pc,     32'h0);
        checkOutput("mid_rst_out",   inst_out,    32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
